// File: rtl/mult_rr_scheduler.sv
// Round-robin front end sharing one Start/Done multiplier among N_REQ requesters.
// Captures the winner's operands, runs the handshake and returns product or timeout error.
module mult_rr_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] opa_flat,
  input  logic [N_REQ*WIDTH-1:0] opb_flat,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]     rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [7:0]             err_count,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic                   mul_done,
  input  logic [2*WIDTH-1:0]     mul_result
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] START_LO  = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;

  logic [2:0]       state, state_d;
  logic [PW-1:0]    rr_ptr, win, win_sel, cand;
  logic             found;
  logic [TW-1:0]    timer;
  logic             timeout;
  logic [N_REQ-1:0] win_oh, sel_oh;

  // Search starts just above the last winner so it ends up with lowest priority.
  always_comb begin
    found   = 1'b0;
    win_sel = rr_ptr;
    cand    = rr_ptr;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = PW'((32'(rr_ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_sel = cand;
      end
    end
  end

  assign timeout = (timer == TW'(TIMEOUT - 1));
  assign win_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << win;
  assign sel_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << win_sel;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (found) state_d = START;
      START:     state_d = START_LO;
      START_LO:  state_d = WAIT_DONE;
      WAIT_DONE: if (mul_done || timeout) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= PW'(N_REQ - 1);
      win       <= '0;
      timer     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      err_count <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      state     <= state_d;
      busy      <= (state_d != IDLE);
      gnt       <= '0;
      rsp_valid <= '0;
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            win       <= win_sel;
            rr_ptr    <= win_sel;
            mul_a     <= opa_flat[32'(win_sel)*WIDTH +: WIDTH];
            mul_b     <= opb_flat[32'(win_sel)*WIDTH +: WIDTH];
            gnt       <= sel_oh;
            mul_start <= 1'b1;
          end
        end
        START_LO: timer <= '0;
        WAIT_DONE: begin
          timer <= timer + 1'b1;
          // Done takes precedence over a coincident timeout.
          if (mul_done) begin
            rsp_data  <= mul_result;
            rsp_err   <= 1'b0;
            rsp_valid <= win_oh;
          end else if (timeout) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= win_oh;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler; the bench itself plays the multiplier.
module tb_mult_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] opa_flat, opb_flat;
  logic [3:0]  gnt, rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err, busy;
  logic [7:0]  err_count;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        mul_done;
  logic [15:0] mul_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_rr_scheduler #(.N_REQ(4), .WIDTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .opa_flat(opa_flat), .opb_flat(opb_flat),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .err_count(err_count), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_result(mul_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next grant pulse.
  task automatic wait_gnt(input string tag, input int exp);
    int n = 0;
    step();
    while (gnt == 4'b0 && n < 10) begin
      step();
      n++;
    end
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp));
    chk({tag, ".mul_start"}, 32'(mul_start), 1);
  endtask

  // Called in START; answers Done dly cycles after Start falls (dly >= 1).
  task automatic finish_op(input string tag, input int dly, input logic [15:0] res,
                           input int exp_rv);
    step();
    chk({tag, ".start_lo"}, 32'(mul_start), 0);
    repeat (dly) step();
    chk({tag, ".pre_rv"}, 32'(rsp_valid), 0);
    mul_done   = 1'b1;
    mul_result = res;
    step();
    mul_done   = 1'b0;
    mul_result = 16'h0;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_rv));
    chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(res));
    chk({tag, ".rsp_err"}, 32'(rsp_err), 0);
    step();
    chk({tag, ".idle_rv"}, 32'(rsp_valid), 0);
    chk({tag, ".idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    req = 4'b0;
    opa_flat = {8'd40, 8'd30, 8'd20, 8'd13};
    opb_flat = {8'd6, 8'd5, 8'd4, 8'd11};
    mul_done = 1'b0;
    mul_result = 16'h0;
    step();
    step();
    chk("rst.gnt", 32'(gnt), 0);
    chk("rst.rsp_valid", 32'(rsp_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.err_count", 32'(err_count), 0);
    chk("rst.mul_start", 32'(mul_start), 0);
    chk("rst.mul_a", 32'(mul_a), 0);
    rst = 1'b0;

    // T1: single request, 13*11.
    req = 4'b0001;
    wait_gnt("t1", 1);
    chk("t1.busy", 32'(busy), 1);
    chk("t1.mul_a", 32'(mul_a), 13);
    chk("t1.mul_b", 32'(mul_b), 11);
    req = 4'b0;
    finish_op("t1", 20, 16'd143, 1);

    // T2: all four at once from reset, order 0,1,2,3.
    rst = 1'b1;
    step();
    rst = 1'b0;
    opa_flat = {8'd40, 8'd30, 8'd20, 8'd10};
    opb_flat = {8'd6, 8'd5, 8'd4, 8'd3};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("t2", 1 << k);
      chk("t2.mul_a", 32'(mul_a), 10 * (k + 1));
      chk("t2.mul_b", 32'(mul_b), k + 3);
      req[k] = 1'b0;
      finish_op("t2", 2, 16'((10 * (k + 1)) * (k + 3)), 1 << k);
    end

    // T3: 0 and 2 held, grants alternate.
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("t3", (k % 2 == 0) ? 1 : 4);
      finish_op("t3", 1, 16'h1230 + 16'(k), (k % 2 == 0) ? 1 : 4);
    end
    req = 4'b0;

    // T4: timeout on requester 2.
    req = 4'b0100;
    wait_gnt("t4", 4);
    req = 4'b0;
    step();
    step();
    bad = 0;
    for (int k = 1; k < 64; k++) begin
      step();
      if (rsp_valid != 4'b0) bad++;
    end
    chk("t4.early_rv", 32'(bad), 0);
    chk("t4.busy_wait", 32'(busy), 1);
    step();
    chk("t4.rsp_valid", 32'(rsp_valid), 4);
    chk("t4.rsp_err", 32'(rsp_err), 1);
    chk("t4.rsp_data", 32'(rsp_data), 0);
    chk("t4.err_count", 32'(err_count), 1);
    step();
    req = 4'b0010;
    wait_gnt("t4n", 2);
    req = 4'b0;
    finish_op("t4n", 5, 16'd777, 2);
    chk("t4n.err_count", 32'(err_count), 1);

    // T5: spurious Done in IDLE and START_LO.
    mul_done = 1'b1;
    mul_result = 16'hBEEF;
    step();
    mul_done = 1'b0;
    chk("t5.idle_busy", 32'(busy), 0);
    chk("t5.idle_rv", 32'(rsp_valid), 0);
    chk("t5.idle_data", 32'(rsp_data), 777);
    req = 4'b1000;
    wait_gnt("t5", 8);
    req = 4'b0;
    step();
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    chk("t5.lo_rv", 32'(rsp_valid), 0);
    chk("t5.lo_busy", 32'(busy), 1);
    repeat (3) step();
    chk("t5.wait_rv", 32'(rsp_valid), 0);
    mul_done = 1'b1;
    mul_result = 16'd55;
    step();
    mul_done = 1'b0;
    chk("t5.rsp_valid", 32'(rsp_valid), 8);
    chk("t5.rsp_data", 32'(rsp_data), 55);
    step();

    // T6: reset while in WAIT_DONE.
    req = 4'b0010;
    wait_gnt("t6", 2);
    req = 4'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6.gnt", 32'(gnt), 0);
    chk("t6.rsp_valid", 32'(rsp_valid), 0);
    chk("t6.busy", 32'(busy), 0);
    chk("t6.mul_start", 32'(mul_start), 0);
    chk("t6.mul_a", 32'(mul_a), 0);
    chk("t6.rsp_data", 32'(rsp_data), 0);
    chk("t6.err_count", 32'(err_count), 0);
    mul_done = 1'b1;
    mul_result = 16'd99;
    step();
    mul_done = 1'b0;
    chk("t6.post_rv", 32'(rsp_valid), 0);
    chk("t6.post_busy", 32'(busy), 0);
    req = 4'b1001;
    wait_gnt("t6a", 1);
    req[0] = 1'b0;
    finish_op("t6a", 1, 16'd30, 1);
    wait_gnt("t6b", 8);
    req = 4'b0;
    finish_op("t6b", 1, 16'd240, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
